// File: rtl/fetch_unit_if.sv
// Fetch stage bus: instruction-memory request/ack, redirect input and decode-side valid/ready.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        fetch_fault;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
           id_opcode, id_funct3, fetch_fault,
    input  imem_ack, imem_rdata, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
           id_opcode, id_funct3, fetch_fault,
    output imem_ack, imem_rdata, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32 fetch: ack in cycle N presents the instruction in N+1; requests stop while the buffer is full.
// Redirect flushes in-flight and buffered words; a misaligned target parks the stage in S_FAULT.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [0:0] {S_FETCH, S_FAULT} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_fetch_pc;
  logic [31:0]        r_instr_q [FIFO_DEPTH];
  logic [31:0]        r_pc_q    [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_full;
  logic               w_aligned;
  logic               w_req;
  logic               w_valid;
  logic               w_push;
  logic               w_pop;
  logic [31:0]        w_id_instr;
  logic [31:0]        w_id_pc;

  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_aligned = (bus.redirect_pc[1:0] == 2'b00);

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_valid     = 1'b0;
    if (bus.redirect) begin
      w_state_nxt = w_aligned ? S_FETCH : S_FAULT;
    end else if (!rst && r_state == S_FETCH) begin
      w_req   = !w_full;
      w_valid = (r_count != '0);
    end
  end

  assign w_push = w_req && bus.imem_ack;
  assign w_pop  = w_valid && bus.id_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else if (bus.redirect) begin
      r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_wr_ptr   <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_instr_q[r_wr_ptr] <= bus.imem_rdata;
      r_pc_q[r_wr_ptr]    <= r_fetch_pc;
    end
  end

  assign w_id_instr = w_valid ? r_instr_q[r_rd_ptr] : NOP;
  assign w_id_pc    = w_valid ? r_pc_q[r_rd_ptr]    : 32'h0;

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_fetch_pc;
  assign bus.id_valid    = w_valid;
  assign bus.id_instr    = w_id_instr;
  assign bus.id_pc       = w_id_pc;
  assign bus.id_pc_plus4 = w_id_pc + 32'd4;
  assign bus.id_opcode   = w_id_instr[6:0];
  assign bus.id_funct3   = w_id_instr[14:12];
  assign bus.fetch_fault = (r_state == S_FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, back-pressure, redirects, fault, wrap, slow memory.
module tb_fetch_unit;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   n_acc;
  int   n_vld;
  logic [31:0] exp_pc;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory image: word at 0 is 0x00A00093, other addresses give distinct words.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h00A0_0093;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.imem_ack = 1'b1;
    bus.id_ready = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;

    // Reset state
    tick(); tick();
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_vld", 32'(bus.id_valid), 32'd0);
    chk("rst_instr", bus.id_instr, 32'h0000_0013);
    chk("rst_pc", bus.id_pc, 32'h0);
    chk("rst_fault", 32'(bus.fetch_fault), 32'd0);

    // First request, then streaming at one per cycle
    rst = 1'b0; #1;
    chk("c1_req", 32'(bus.imem_req), 32'd1);
    chk("c1_addr", bus.imem_addr, 32'h0);
    chk("c1_vld", 32'(bus.id_valid), 32'd0);
    tick(); #1;
    chk("c2_opcode", 32'(bus.id_opcode), 32'h13);
    chk("c2_funct3", 32'(bus.id_funct3), 32'h0);
    chk("c2_instr", bus.id_instr, 32'h00A0_0093);
    for (int i = 0; i < 4; i++) begin
      chk("stream_vld", 32'(bus.id_valid), 32'd1);
      chk("stream_pc", bus.id_pc, 32'(4 * i));
      chk("stream_pc4", bus.id_pc_plus4, 32'(4 * i + 4));
      chk("stream_instr", bus.id_instr, mem_word(32'(4 * i)));
      tick(); #1;
    end

    // Reset mid-stream, then back-pressure with a 2-deep buffer
    rst = 1'b1; #1;
    chk("rst2_req", 32'(bus.imem_req), 32'd0);
    chk("rst2_vld", 32'(bus.id_valid), 32'd0);
    tick();
    rst = 1'b0; bus.id_ready = 1'b0; #1;
    chk("bp_addr0", bus.imem_addr, 32'h0);
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.imem_req && bus.imem_ack) n_acc++;
      tick(); #1;
    end
    chk("bp_acks", 32'(n_acc), 32'd2);
    chk("bp_req", 32'(bus.imem_req), 32'd0);
    chk("bp_head", bus.id_pc, 32'h0);
    bus.id_ready = 1'b1; #1;
    chk("bp_full_pop_req", 32'(bus.imem_req), 32'd0);
    chk("bp_rel_pc0", bus.id_pc, 32'h0);
    tick(); #1;
    chk("bp_rel_pc4", bus.id_pc, 32'h4);
    chk("bp_resume_addr", bus.imem_addr, 32'h8);
    chk("bp_resume_req", 32'(bus.imem_req), 32'd1);
    tick(); #1;
    chk("bp_rel_pc8", bus.id_pc, 32'h8);

    // Fill the buffer, then redirect with ack high
    bus.id_ready = 1'b0;
    tick(); #1;
    chk("fill_req", 32'(bus.imem_req), 32'd0);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0100; bus.id_ready = 1'b1; #1;
    chk("rd_vld", 32'(bus.id_valid), 32'd0);
    chk("rd_req", 32'(bus.imem_req), 32'd0);
    chk("rd_instr", bus.id_instr, 32'h0000_0013);
    tick();
    bus.redirect = 1'b0; #1;
    chk("rd_addr", bus.imem_addr, 32'h100);
    chk("rd_req1", 32'(bus.imem_req), 32'd1);
    chk("rd_vld1", 32'(bus.id_valid), 32'd0);
    tick(); #1;
    chk("rd_first_pc", bus.id_pc, 32'h100);
    chk("rd_first_instr", bus.id_instr, 32'h00A0_0193);

    // Misaligned redirect and recovery
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0102; #1;
    tick();
    bus.redirect = 1'b0; #1;
    chk("mis_fault", 32'(bus.fetch_fault), 32'd1);
    chk("mis_req", 32'(bus.imem_req), 32'd0);
    chk("mis_vld", 32'(bus.id_valid), 32'd0);
    chk("mis_instr", bus.id_instr, 32'h0000_0013);
    chk("mis_addr", bus.imem_addr, 32'h100);
    tick(); tick(); #1;
    chk("mis_hold_fault", 32'(bus.fetch_fault), 32'd1);
    chk("mis_hold_req", 32'(bus.imem_req), 32'd0);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0200; #1;
    tick();
    bus.redirect = 1'b0; #1;
    chk("rec_fault", 32'(bus.fetch_fault), 32'd0);
    chk("rec_addr", bus.imem_addr, 32'h200);
    tick(); #1;
    chk("rec_pc", bus.id_pc, 32'h200);

    // Address wrap
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC; #1;
    tick();
    bus.redirect = 1'b0; #1;
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    tick(); #1;
    chk("wrap_pc_a", bus.id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4_a", bus.id_pc_plus4, 32'h0);
    chk("wrap_instr_a", bus.id_instr, 32'hFF5F_FF6F);
    chk("wrap_addr_next", bus.imem_addr, 32'h0);
    tick(); #1;
    chk("wrap_pc_b", bus.id_pc, 32'h0);
    chk("wrap_pc4_b", bus.id_pc_plus4, 32'h4);

    // Slow memory: ack every third cycle, then reset mid-request
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0040; bus.imem_ack = 1'b0; #1;
    tick();
    bus.redirect = 1'b0;
    exp_pc = 32'h40;
    n_vld = 0;
    for (int k = 0; k < 7; k++) begin
      bus.imem_ack = ((k % 3) == 2); #1;
      chk("slow_req", 32'(bus.imem_req), 32'd1);
      if (bus.id_valid) begin
        chk("slow_pc", bus.id_pc, exp_pc);
        chk("slow_instr", bus.id_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_vld++;
      end
      tick();
    end
    chk("slow_count", 32'(n_vld), 32'd2);
    bus.imem_ack = 1'b0; rst = 1'b1; #1;
    chk("slow_rst_req", 32'(bus.imem_req), 32'd0);
    chk("slow_rst_vld", 32'(bus.id_valid), 32'd0);
    tick();
    rst = 1'b0; #1;
    chk("post_rst_addr", bus.imem_addr, 32'h0);
    chk("post_rst_req", 32'(bus.imem_req), 32'd1);
    chk("post_rst_vld", 32'(bus.id_valid), 32'd0);
    chk("post_rst_fault", 32'(bus.fetch_fault), 32'd0);
    bus.imem_ack = 1'b1;
    tick(); #1;
    chk("post_rst_pc", bus.id_pc, 32'h0);
    chk("post_rst_instr", bus.id_instr, 32'h00A0_0093);

    // Reset while faulted
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0006; #1;
    tick();
    bus.redirect = 1'b0; #1;
    chk("f2_fault", 32'(bus.fetch_fault), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("f2_rst_fault", 32'(bus.fetch_fault), 32'd0);
    chk("f2_rst_req", 32'(bus.imem_req), 32'd1);
    chk("f2_rst_addr", bus.imem_addr, 32'h0);
    chk("f2_rst_vld", 32'(bus.id_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
